multicycle_ctrlu: RTL and testbench
===================================

# multicycle_ctrlu

- Multi-cycle control unit for the RV32I core, the next generation of the single-cycle decoder.
- A registered state machine sequences each instruction over 3–5 cycles and drives the datapath muxes, enables and ALU control.
- Extends the decoded set from addi/bne to lw, sw, R-type ALU ops, I-type ALU ops, beq, bne and jal.
- Adds a memory-ready handshake, an illegal-instruction trap and a retired-instruction counter.

## Interface
- MEM_HANDSHAKE, 1, 1: memory states wait for mem_ready; 0: mem_ready is ignored and treated as 1.
- ALUCTRL_W, 3, alu_ctrl width (≥3); bits above [2] are driven 0.
- CNT_W, 32, instret width.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- op  in  7  instruction opcode field (IR[6:0]).
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- EQ  in  1  ALU operands equal (rs1 == rs2).
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction and OldPC register enable.
- result_src  out  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- alu_ctrl  out  ALUCTRL_W  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- reg_write  out  1  register file write enable.
- illegal  out  1  sticky trap flag.
- instret  out  CNT_W  count of retired instructions.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- Outputs are combinational from state, op, funct3, funct7b5, EQ and mem_ready.
- Every output not listed for a state is 0. alu_ctrl defaults to add.

Per-state outputs and transitions:
- FETCH
  - Outputs: adr_src = 0, alu_src_a = 00, alu_src_b = 10, add, result_src = 10.
  - ir_write = pc_write = mem_ready.
  - Next: DECODE when mem_ready, else stay in FETCH.
- DECODE
  - Outputs: alu_src_a = 01, alu_src_b = 01, add (computes branch/jump target); imm_src from op.
  - Next, by opcode:
    - 0000011 (lw) or 0100011 (sw) → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 with funct3 000 or 001 → BRANCH
    - 1101111 → JAL
    - any other op or funct3 → TRAP
  - R-type and I-type funct3 other than 000, 010, 110 or 111 → TRAP.
- MEMADR
  - Outputs: alu_src_a = 10, alu_src_b = 01, add, imm_src = 00 (lw) or 01 (sw).
  - Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD
  - Outputs: adr_src = 1.
  - Next: MEMWB on mem_ready, else hold.
- MEMWB
  - Outputs: result_src = 01, reg_write = 1.
  - Next: FETCH.
- MEMWRITE
  - Outputs: adr_src = 1; mem_write = 1 on every cycle in the state.
  - Next: FETCH on mem_ready, else hold.
- EXECR
  - Outputs: alu_src_a = 10, alu_src_b = 00.
  - Next: ALUWB.
- EXECI
  - Outputs: alu_src_a = 10, alu_src_b = 01, imm_src = 00.
  - Next: ALUWB.
- ALU decode (EXECR and EXECI)
  - funct3 000: add; sub only in EXECR with funct7b5 = 1.
  - funct3 010: slt. funct3 110: or. funct3 111: and.
- ALUWB
  - Outputs: result_src = 00, reg_write = 1.
  - Next: FETCH.
- BRANCH
  - Outputs: alu_src_a = 10, alu_src_b = 00, sub, result_src = 00.
  - pc_write = (funct3 == 000 & EQ) | (funct3 == 001 & ~EQ).
  - Next: FETCH.
- JAL
  - Outputs: alu_src_a = 01, alu_src_b = 10, add, result_src = 00, pc_write = 1.
  - Next: ALUWB (writes PC+4 to rd).
- TRAP
  - Outputs: illegal = 1; all enables 0.
  - Next: stays in TRAP until rst.
- instret
  - Increments by 1 on the last cycle of each instruction: ALUWB, MEMWB, BRANCH, and MEMWRITE with mem_ready.
  - Wraps modulo 2^CNT_W.
  - Does not count TRAP.

## Timing
- Reset
  - rst asynchronously forces state = FETCH, instret = 0, illegal = 0.
  - While rst = 1, pc_write, ir_write, mem_write and reg_write are forced to 0.
  - After rst deasserts, first fetch is on the next edge with mem_ready.
- Zero-wait cycle counts:
  - R-type and I-type: 4
  - lw: 5
  - sw: 4
  - beq/bne: 3
  - jal: 4 (FETCH, DECODE, JAL, ALUWB)
- Each cycle with mem_ready = 0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- While waiting, outputs are held constant.
- Reset mid-instruction
  - No partial writeback.
  - The enable outputs drop combinationally with rst.
- With MEM_HANDSHAKE = 0, cycle counts are fixed regardless of mem_ready.

## Test plan
- addi (op 0010011, funct3 000), mem_ready = 1 → 4 cycles; reg_write = 1 in cycle 4 only, alu_ctrl = 000 in EXECI; instret 0 → 1.
- lw with mem_ready low for 2 cycles in MEMREAD → 7 cycles total; adr_src = 1 throughout MEMREAD; result_src = 01 and reg_write = 1 in MEMWB.
- bne (funct3 001): EQ = 0 → pc_write = 1 in BRANCH; EQ = 1 → pc_write = 0; both 3 cycles with alu_ctrl = 001.
- R-type sub (funct3 000, funct7b5 = 1) → alu_ctrl = 001 in EXECR; a following jal → pc_write = 1 in JAL, reg_write = 1 in ALUWB.
- op 1110011 → TRAP; illegal = 1 held for 10 cycles, instret frozen; rst → FETCH, illegal = 0.
- CNT_W = 4: 17 back-to-back addi → instret = 1 (wrap). rst asserted mid-MEMWRITE → mem_write drops the same cycle, instret = 0.

Source files
------------

// File: rtl/multicycle_ctrlu_if.sv
// Control bundle between the multi-cycle sequencer and the RV32I datapath.
// Master is the control unit: it drives the datapath controls and reads back the instruction fields.
interface multicycle_ctrlu_if #(
  parameter int ALUCTRL_W = 3,
  parameter int CNT_W     = 32
);
  logic [6:0]           op;
  logic [2:0]           funct3;
  logic                 funct7b5;
  logic                 eq;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 adr_src;
  logic                 mem_write;
  logic                 ir_write;
  logic [1:0]           result_src;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           imm_src;
  logic [ALUCTRL_W-1:0] alu_ctrl;
  logic                 reg_write;
  logic                 illegal;
  logic [CNT_W-1:0]     instret;

  modport master (
    input  op, funct3, funct7b5, eq, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_ctrl, reg_write, illegal, instret
  );

  modport slave (
    output op, funct3, funct7b5, eq, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_ctrl, reg_write, illegal, instret
  );
endinterface

// File: rtl/multicycle_ctrlu.sv
// Multi-cycle RV32I control unit: 3-5 cycles per instruction, waits on mem_ready in memory states.
// Outputs are combinational from state and instruction fields; enables are masked while rst is high.
module multicycle_ctrlu #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int ALUCTRL_W     = 3,
  parameter int CNT_W         = 32
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrlu_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic       mem_rdy;
  logic       alu_f3_ok;
  logic [2:0] alu_dec;
  logic       retire;

  logic       pc_write_c, adr_src_c, mem_write_c, ir_write_c, reg_write_c;
  logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, imm_src_c;
  logic [2:0] alu_op_c;

  assign mem_rdy   = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign alu_f3_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b010) ||
                     (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);

  // funct7b5 only selects sub for register-register ops; addi ignores it
  always_comb begin
    alu_dec = ALU_ADD;
    case (bus.funct3)
      3'b000:  alu_dec = (state_q == S_EXECR && bus.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_write_c   = 1'b0;
    adr_src_c    = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    result_src_c = 2'b00;
    alu_src_a_c  = 2'b00;
    alu_src_b_c  = 2'b00;
    imm_src_c    = 2'b00;
    alu_op_c     = ALU_ADD;
    retire       = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        ir_write_c   = mem_rdy;
        pc_write_c   = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
        case (bus.op)
          OP_SW:   imm_src_c = 2'b01;
          OP_BR:   imm_src_c = 2'b10;
          OP_JAL:  imm_src_c = 2'b11;
          default: imm_src_c = 2'b00;
        endcase
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = alu_f3_ok ? S_EXECR : S_TRAP;
          OP_I:         state_d = alu_f3_ok ? S_EXECI : S_TRAP;
          OP_BR:        state_d = (bus.funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        imm_src_c   = (bus.op == OP_SW) ? 2'b01 : 2'b00;
        state_d     = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src_c = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
        retire      = mem_rdy;
        if (mem_rdy) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = alu_dec;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        alu_op_c    = alu_dec;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = ALU_SUB;
        pc_write_c  = (bus.funct3 == 3'b000 && bus.eq) || (bus.funct3 == 3'b001 && !bus.eq);
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b10;
        pc_write_c  = 1'b1;
        state_d     = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    instret_d = instret_q + CNT_W'(retire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Enables drop combinationally with rst so a mid-instruction reset never writes back
  assign bus.pc_write   = pc_write_c  & ~rst;
  assign bus.ir_write   = ir_write_c  & ~rst;
  assign bus.mem_write  = mem_write_c & ~rst;
  assign bus.reg_write  = reg_write_c & ~rst;
  assign bus.adr_src    = adr_src_c;
  assign bus.result_src = result_src_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.imm_src    = imm_src_c;
  assign bus.alu_ctrl   = ALUCTRL_W'(alu_op_c);
  assign bus.illegal    = (state_q == S_TRAP);
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrlu.sv
// Scoreboard bench for multicycle_ctrlu: the driver queues a hand-written control word per cycle,
// a negedge monitor pops and compares; a second small-counter instance checks instret wrap.
module tb_multicycle_ctrlu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrlu_if #(.ALUCTRL_W(3), .CNT_W(32)) bus ();
  multicycle_ctrlu_if #(.ALUCTRL_W(3), .CNT_W(4))  bus4 ();

  multicycle_ctrlu #(.MEM_HANDSHAKE(1'b1), .ALUCTRL_W(3), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  multicycle_ctrlu #(.MEM_HANDSHAKE(1'b0), .ALUCTRL_W(3), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst4), .bus(bus4)
  );

  // control word: pc_write adr_src mem_write ir_write | result_src alu_src_a alu_src_b imm_src | alu_ctrl | reg_write illegal
  typedef struct {
    logic [16:0] ctl;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_cnt = 0;
  logic [16:0] act;

  assign act = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
                bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.alu_ctrl, bus.reg_write, bus.illegal};

  localparam logic [16:0] W_F1   = {4'b1001, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00};
  localparam logic [16:0] W_FW   = {4'b0000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00};
  localparam logic [16:0] W_MALW = {4'b0000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 2'b00};
  localparam logic [16:0] W_MASW = {4'b0000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 2'b00};
  localparam logic [16:0] W_MR   = {4'b0100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [16:0] W_MWB  = {4'b0000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10};
  localparam logic [16:0] W_MW   = {4'b0110, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [16:0] W_AWB  = {4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10};
  localparam logic [16:0] W_JAL  = {4'b1000, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 2'b00};
  localparam logic [16:0] W_TRAP = {4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01};

  function automatic logic [16:0] w_dec(input logic [1:0] im);
    return {4'b0000, 2'b00, 2'b01, 2'b01, im, 3'b000, 2'b00};
  endfunction
  function automatic logic [16:0] w_exr(input logic [2:0] ac);
    return {4'b0000, 2'b00, 2'b10, 2'b00, 2'b00, ac, 2'b00};
  endfunction
  function automatic logic [16:0] w_exi(input logic [2:0] ac);
    return {4'b0000, 2'b00, 2'b10, 2'b01, 2'b00, ac, 2'b00};
  endfunction
  function automatic logic [16:0] w_br(input logic pw);
    return {pw, 3'b000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 2'b00};
  endfunction

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic eq);
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.eq = eq;
  endtask

  // one clock cycle: queue the expected word, advance, then account for a retire
  task automatic step(input logic [16:0] w, input bit retire, input string tag);
    exp_t e;
    e.ctl = w; e.cnt = exp_cnt; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk); #1;
    if (retire) exp_cnt = exp_cnt + 1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_chk++;
      if (act !== e.ctl || bus.instret !== e.cnt) begin
        n_fail++;
        $display("FAIL %s: ctl got %b want %b, instret got %0d want %0d",
                 e.tag, act, e.ctl, bus.instret, e.cnt);
      end
    end
  end

  initial begin
    set_in(7'b0010011, 3'b000, 1'b0, 1'b0);
    bus.mem_ready = 1'b1;
    bus4.op = 7'b0010011; bus4.funct3 = 3'b000; bus4.funct7b5 = 1'b0;
    bus4.eq = 1'b0; bus4.mem_ready = 1'b0;

    @(posedge clk); #1;
    step(W_FW, 0, "reset_hold");
    rst = 1'b0;

    // addi
    step(W_F1, 0, "addi_fetch");
    step(w_dec(2'b00), 0, "addi_decode");
    step(w_exi(3'b000), 0, "addi_execi");
    step(W_AWB, 1, "addi_aluwb");

    // lw with two MEMREAD wait cycles
    set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
    step(W_F1, 0, "lw_fetch");
    step(w_dec(2'b00), 0, "lw_decode");
    step(W_MALW, 0, "lw_memadr");
    bus.mem_ready = 1'b0;
    step(W_MR, 0, "lw_memread_w1");
    step(W_MR, 0, "lw_memread_w2");
    bus.mem_ready = 1'b1;
    step(W_MR, 0, "lw_memread_go");
    step(W_MWB, 1, "lw_memwb");

    // sw with a FETCH wait and a MEMWRITE wait
    set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
    bus.mem_ready = 1'b0;
    step(W_FW, 0, "sw_fetch_wait");
    bus.mem_ready = 1'b1;
    step(W_F1, 0, "sw_fetch");
    step(w_dec(2'b01), 0, "sw_decode");
    step(W_MASW, 0, "sw_memadr");
    bus.mem_ready = 1'b0;
    step(W_MW, 0, "sw_memwrite_wait");
    bus.mem_ready = 1'b1;
    step(W_MW, 1, "sw_memwrite_go");

    // bne taken / not taken, beq taken
    set_in(7'b1100011, 3'b001, 1'b0, 1'b0);
    step(W_F1, 0, "bne_fetch");
    step(w_dec(2'b10), 0, "bne_decode");
    step(w_br(1'b1), 1, "bne_ne_taken");
    set_in(7'b1100011, 3'b001, 1'b0, 1'b1);
    step(W_F1, 0, "bne2_fetch");
    step(w_dec(2'b10), 0, "bne2_decode");
    step(w_br(1'b0), 1, "bne_eq_not_taken");
    set_in(7'b1100011, 3'b000, 1'b0, 1'b1);
    step(W_F1, 0, "beq_fetch");
    step(w_dec(2'b10), 0, "beq_decode");
    step(w_br(1'b1), 1, "beq_eq_taken");

    // R-type sub then jal
    set_in(7'b0110011, 3'b000, 1'b1, 1'b0);
    step(W_F1, 0, "sub_fetch");
    step(w_dec(2'b00), 0, "sub_decode");
    step(w_exr(3'b001), 0, "sub_execr");
    step(W_AWB, 1, "sub_aluwb");
    set_in(7'b1101111, 3'b000, 1'b0, 1'b0);
    step(W_F1, 0, "jal_fetch");
    step(w_dec(2'b11), 0, "jal_decode");
    step(W_JAL, 0, "jal_jal");
    step(W_AWB, 1, "jal_aluwb");

    // ALU decode variants: slt, or (I-type with funct7b5 set), and
    set_in(7'b0110011, 3'b010, 1'b0, 1'b0);
    step(W_F1, 0, "slt_fetch");
    step(w_dec(2'b00), 0, "slt_decode");
    step(w_exr(3'b101), 0, "slt_execr");
    step(W_AWB, 1, "slt_aluwb");
    set_in(7'b0010011, 3'b110, 1'b1, 1'b0);
    step(W_F1, 0, "ori_fetch");
    step(w_dec(2'b00), 0, "ori_decode");
    step(w_exi(3'b011), 0, "ori_execi");
    step(W_AWB, 1, "ori_aluwb");
    set_in(7'b0110011, 3'b111, 1'b0, 1'b0);
    step(W_F1, 0, "and_fetch");
    step(w_dec(2'b00), 0, "and_decode");
    step(w_exr(3'b010), 0, "and_execr");
    step(W_AWB, 1, "and_aluwb");

    // reset while MEMWRITE waits
    set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
    step(W_F1, 0, "sw2_fetch");
    step(w_dec(2'b01), 0, "sw2_decode");
    step(W_MASW, 0, "sw2_memadr");
    bus.mem_ready = 1'b0;
    step(W_MW, 0, "sw2_memwrite_wait");
    rst = 1'b1;
    exp_cnt = 0;
    step(W_FW, 0, "rst_mid_memwrite");
    rst = 1'b0;
    bus.mem_ready = 1'b1;

    // unsupported opcode traps; counter frozen
    set_in(7'b1110011, 3'b000, 1'b0, 1'b0);
    step(W_F1, 0, "ecall_fetch");
    step(w_dec(2'b00), 0, "ecall_decode");
    for (int i = 0; i < 10; i++) step(W_TRAP, 0, "trap_hold");
    rst = 1'b1;
    step(W_FW, 0, "trap_reset");
    rst = 1'b0;

    // R-type with an unsupported funct3 traps too
    set_in(7'b0110011, 3'b001, 1'b0, 1'b0);
    step(W_F1, 0, "badf3_fetch");
    step(w_dec(2'b00), 0, "badf3_decode");
    step(W_TRAP, 0, "badf3_trap");
    rst = 1'b1;
    step(W_FW, 0, "badf3_reset");
    rst = 1'b0;

    set_in(7'b0010011, 3'b000, 1'b0, 1'b0);
    step(W_F1, 0, "post_fetch");
    step(w_dec(2'b00), 0, "post_decode");
    step(w_exi(3'b000), 0, "post_execi");
    step(W_AWB, 1, "post_aluwb");
    step(W_F1, 0, "post_next_fetch");

    // 4-bit counter, handshake disabled with mem_ready held low: 17 addi wrap to 1
    rst4 = 1'b0;
    repeat (64) @(posedge clk);
    #1;
    n_chk++;
    if (bus4.instret !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap16: instret got %0d want 0", bus4.instret);
    end
    repeat (4) @(posedge clk);
    #1;
    n_chk++;
    if (bus4.instret !== 4'd1) begin
      n_fail++;
      $display("FAIL wrap17: instret got %0d want 1", bus4.instret);
    end

    @(posedge clk); #1;
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: left %0d want 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
